// File: rtl/snn_spike_flatten.sv
// Spike coordinate flattener for the layer after 2D average pooling.
// Maps each (ch, y, x) spike event to a linear neuron index in (C, H, W) order.
// A two-stage index pipeline feeds a first-word-fall-through output FIFO.
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   enable                   gates input acceptance only
//   s_axis_input_*           input events {valid, ch, y, x} with tlast
//   m_axis_output_*          output {8'h01, pad, index}, or 32'h0 marker beats
//   clear_counters           synchronous clear of the three status counters
//   input_spike_count        accepted beats with a nonzero valid byte
//   output_spike_count       emitted beats with a nonzero valid byte
//   drop_count               out-of-range spikes discarded
//   fifo_level               current output FIFO occupancy
module snn_spike_flatten #(
    parameter int unsigned IN_WIDTH    = 14,
    parameter int unsigned IN_HEIGHT   = 14,
    parameter int unsigned IN_CHANNELS = 32,
    parameter int unsigned INDEX_WIDTH = 16,
    parameter int unsigned FIFO_DEPTH  = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          enable,
    input  logic [31:0]                   s_axis_input_tdata,
    input  logic                          s_axis_input_tvalid,
    output logic                          s_axis_input_tready,
    input  logic                          s_axis_input_tlast,
    output logic [31:0]                   m_axis_output_tdata,
    output logic                          m_axis_output_tvalid,
    input  logic                          m_axis_output_tready,
    output logic                          m_axis_output_tlast,
    input  logic                          clear_counters,
    output logic [31:0]                   input_spike_count,
    output logic [31:0]                   output_spike_count,
    output logic [31:0]                   drop_count,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;
    localparam int unsigned HW    = IN_HEIGHT * IN_WIDTH;

    // Stage 1: captured coordinates and partial products
    logic                   s1_valid, s1_spike, s1_tlast, s1_in_range;
    logic [INDEX_WIDTH-1:0] s1_ch_prod, s1_y_prod, s1_x;
    // Stage 2: final index and classification inputs
    logic                   s2_valid, s2_spike, s2_tlast, s2_in_range;
    logic [INDEX_WIDTH-1:0] s2_index;

    // Output FIFO storage: {tlast, tdata}
    logic [32:0]            mem [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr, rd_ptr;
    logic [LVL_W-1:0]       level;
    logic                   running;

    logic                   accept, push, pop;
    logic [31:0]            push_word;
    logic [32:0]            head;
    logic [LVL_W:0]         committed;

    // Room is reserved for every beat already in the pipeline, so the FIFO can never overflow
    assign committed = (LVL_W+1)'(level) + (LVL_W+1)'(s1_valid) + (LVL_W+1)'(s2_valid);
    assign s_axis_input_tready = running && enable && (committed < (LVL_W+1)'(FIFO_DEPTH));
    assign accept = s_axis_input_tvalid && s_axis_input_tready;

    // In-range spikes carry their index; everything else that is written is a timestep marker
    assign push = s2_valid && (s2_tlast || (s2_spike && s2_in_range));
    assign push_word = (s2_spike && s2_in_range) ? (32'(s2_index) | 32'h0100_0000) : 32'h0;

    assign head = mem[rd_ptr];
    assign m_axis_output_tvalid = (level != '0);
    assign m_axis_output_tdata  = m_axis_output_tvalid ? head[31:0] : 32'h0;
    assign m_axis_output_tlast  = m_axis_output_tvalid && head[32];
    assign pop = m_axis_output_tvalid && m_axis_output_tready;
    assign fifo_level = level;

    // Index pipeline; never stalls because FIFO space is reserved at acceptance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            running     <= 1'b0;
            s1_valid    <= 1'b0;
            s1_spike    <= 1'b0;
            s1_tlast    <= 1'b0;
            s1_in_range <= 1'b0;
            s1_ch_prod  <= '0;
            s1_y_prod   <= '0;
            s1_x        <= '0;
            s2_valid    <= 1'b0;
            s2_spike    <= 1'b0;
            s2_tlast    <= 1'b0;
            s2_in_range <= 1'b0;
            s2_index    <= '0;
        end else begin
            running  <= 1'b1;
            s1_valid <= accept;
            if (accept) begin
                s1_spike    <= (s_axis_input_tdata[31:24] != 8'h00);
                s1_tlast    <= s_axis_input_tlast;
                s1_in_range <= (32'(s_axis_input_tdata[23:16]) < IN_CHANNELS) &&
                               (32'(s_axis_input_tdata[15:8])  < IN_HEIGHT) &&
                               (32'(s_axis_input_tdata[7:0])   < IN_WIDTH);
                s1_ch_prod  <= INDEX_WIDTH'(s_axis_input_tdata[23:16]) * INDEX_WIDTH'(HW);
                s1_y_prod   <= INDEX_WIDTH'(s_axis_input_tdata[15:8]) * INDEX_WIDTH'(IN_WIDTH);
                s1_x        <= INDEX_WIDTH'(s_axis_input_tdata[7:0]);
            end
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_spike    <= s1_spike;
                s2_tlast    <= s1_tlast;
                s2_in_range <= s1_in_range;
                s2_index    <= s1_ch_prod + s1_y_prod + s1_x;
            end
        end
    end

    // FIFO storage has no reset; the level gates what is visible
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {s2_tlast, push_word};
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop)      level <= level + LVL_W'(1);
            else if (pop && !push) level <= level - LVL_W'(1);
        end
    end

    // Status counters; a clear overrides a coincident increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            input_spike_count  <= '0;
            output_spike_count <= '0;
            drop_count         <= '0;
        end else if (clear_counters) begin
            input_spike_count  <= '0;
            output_spike_count <= '0;
            drop_count         <= '0;
        end else begin
            if (accept && (s_axis_input_tdata[31:24] != 8'h00))
                input_spike_count <= input_spike_count + 32'd1;
            if (pop && (head[31:24] != 8'h00))
                output_spike_count <= output_spike_count + 32'd1;
            if (s2_valid && s2_spike && !s2_in_range)
                drop_count <= drop_count + 32'd1;
        end
    end

endmodule

// File: tb/tb_snn_spike_flatten.sv
module tb_snn_spike_flatten;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [31:0] s_tdata;
    logic        s_tvalid, s_tlast;
    logic        s_tready;
    logic [31:0] m_tdata;
    logic        m_tvalid, m_tlast;
    logic        m_tready;
    logic        clear;
    logic [31:0] in_cnt, out_cnt, drop_cnt;
    logic [4:0]  level;

    int checks = 0;
    int failures = 0;
    int exp_in = 0, exp_out = 0, exp_drop = 0;
    logic [32:0] exp_q[$];
    bit rand_rdy = 0;

    always #5 clk = ~clk;

    snn_spike_flatten dut (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .s_axis_input_tdata(s_tdata), .s_axis_input_tvalid(s_tvalid),
        .s_axis_input_tready(s_tready), .s_axis_input_tlast(s_tlast),
        .m_axis_output_tdata(m_tdata), .m_axis_output_tvalid(m_tvalid),
        .m_axis_output_tready(m_tready), .m_axis_output_tlast(m_tlast),
        .clear_counters(clear),
        .input_spike_count(in_cnt), .output_spike_count(out_cnt),
        .drop_count(drop_cnt), .fifo_level(level)
    );

    // Reference model: expected output for one accepted beat
    function automatic void model_push(input logic [31:0] d, input logic l);
        int ch, y, x, idx;
        bit inr;
        ch  = int'(d[23:16]);
        y   = int'(d[15:8]);
        x   = int'(d[7:0]);
        inr = (ch < 32) && (y < 14) && (x < 14);
        idx = ch * 196 + y * 14 + x;
        if (d[31:24] != 8'h00) exp_in++;
        if (d[31:24] != 8'h00 && inr)
            exp_q.push_back({l, 32'h0100_0000 | 32'(idx)});
        else begin
            if (d[31:24] != 8'h00) exp_drop++;
            if (l) exp_q.push_back({1'b1, 32'h0});
        end
    endfunction

    // Scoreboard: every output handshake is compared against the model queue
    always @(negedge clk) begin
        if (rst_n && m_tvalid && m_tready) begin
            logic [32:0] e;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_output got=%h last=%b", m_tdata, m_tlast);
            end else begin
                e = exp_q.pop_front();
                if ({m_tlast, m_tdata} !== e) begin
                    failures++;
                    $display("FAIL output_beat got=%h last=%b exp=%h last=%b",
                             m_tdata, m_tlast, e[31:0], e[32]);
                end
                if (e[31:24] != 8'h00) exp_out++;
            end
        end
    end

    always @(posedge clk) begin
        if (rand_rdy) begin
            #1 m_tready = 1'($urandom_range(0, 1));
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] d, input logic l);
        bit done = 0;
        s_tdata = d; s_tlast = l; s_tvalid = 1'b1;
        for (int n = 0; n < 200 && !done; n++) begin
            @(negedge clk);
            if (s_tready) begin
                model_push(d, l);
                done = 1;
            end
            @(posedge clk); #1;
        end
        s_tvalid = 1'b0; s_tlast = 1'b0;
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL send_timeout data=%h tready=%b", d, s_tready);
        end
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clk); n++;
        end
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain_timeout pending=%0d required=0", exp_q.size());
        end
        idle(2);
    endtask

    task automatic check_counters(input string name);
        checks++;
        if (in_cnt !== 32'(exp_in) || out_cnt !== 32'(exp_out) || drop_cnt !== 32'(exp_drop)) begin
            failures++;
            $display("FAIL %s counters got in=%0d out=%0d drop=%0d exp in=%0d out=%0d drop=%0d",
                     name, in_cnt, out_cnt, drop_cnt, exp_in, exp_out, exp_drop);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; enable = 1'b1; s_tdata = '0; s_tvalid = 0; s_tlast = 0;
        m_tready = 1'b1; clear = 0;
        #12;
        checks++;
        if (m_tvalid !== 0 || m_tlast !== 0 || m_tdata !== 32'h0 || s_tready !== 0 || level !== 5'd0) begin
            failures++;
            $display("FAIL reset_outputs got tvalid=%b tlast=%b tdata=%h tready=%b level=%0d required all 0",
                     m_tvalid, m_tlast, m_tdata, s_tready, level);
        end
        check_counters("reset");
        @(posedge clk); #1 rst_n = 1'b1;
        idle(2);
    endtask

    task automatic test_single();
        logic [1:0] seen;
        send(32'h0101_0203, 1'b0);
        @(negedge clk); seen[0] = m_tvalid;
        @(negedge clk); seen[1] = m_tvalid;
        checks++;
        if (seen !== 2'b00) begin
            failures++;
            $display("FAIL single_early_valid got=%b required=00", seen);
        end
        @(negedge clk);
        checks++;
        if (m_tvalid !== 1'b1 || m_tdata !== 32'h0100_00E3 || m_tlast !== 1'b0) begin
            failures++;
            $display("FAIL single_latency got tvalid=%b tdata=%h tlast=%b required 1 010000e3 0",
                     m_tvalid, m_tdata, m_tlast);
        end
        @(negedge clk);
        checks++;
        if (m_tvalid !== 1'b0) begin
            failures++;
            $display("FAIL single_one_cycle got tvalid=%b required=0", m_tvalid);
        end
        checks++;
        if (in_cnt !== 32'd1 || out_cnt !== 32'd1) begin
            failures++;
            $display("FAIL single_counts got in=%0d out=%0d required 1 1", in_cnt, out_cnt);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_max_and_drop();
        send(32'h011F_0D0D, 1'b0);
        send(32'h011F_0D0E, 1'b1);
        drain(50);
        checks++;
        if (drop_cnt !== 32'd1) begin
            failures++;
            $display("FAIL drop_count got=%0d required=1", drop_cnt);
        end
        check_counters("max_drop");
    endtask

    task automatic test_null_beat();
        send(32'h0005_0505, 1'b0);
        @(negedge clk);
        checks++;
        if (s_tready !== 1'b1) begin
            failures++;
            $display("FAIL null_tready got=%b required=1", s_tready);
        end
        @(posedge clk); #1;
        idle(5);
        check_counters("null_no_output");
        send(32'h0005_0505, 1'b1);
        drain(50);
        check_counters("null_marker");
    endtask

    task automatic test_backpressure();
        int acc = 0;
        logic [31:0] d;
        m_tready = 1'b0;
        for (int c = 0; c < 40; c++) begin
            d = {8'h01, 8'(acc % 32), 8'(acc % 14), 8'((acc * 3) % 14)};
            s_tdata = d; s_tlast = 1'b0; s_tvalid = (acc < 20);
            @(negedge clk);
            if (s_tvalid && s_tready) begin
                model_push(d, 1'b0);
                acc++;
            end
            @(posedge clk); #1;
        end
        @(negedge clk);
        checks++;
        if (acc != 16 || level !== 5'd16 || s_tready !== 1'b0) begin
            failures++;
            $display("FAIL backpressure_full got accepted=%0d level=%0d tready=%b required 16 16 0",
                     acc, level, s_tready);
        end
        @(posedge clk); #1;
        s_tvalid = 1'b0;
        m_tready = 1'b1;
        begin
            int run = 0;
            for (int c = 0; c < 16; c++) begin
                @(negedge clk);
                if (m_tvalid) run++;
            end
            checks++;
            if (run != 16) begin
                failures++;
                $display("FAIL backpressure_back_to_back got=%0d required=16", run);
            end
        end
        @(negedge clk);
        checks++;
        if (s_tready !== 1'b1 || level !== 5'd0) begin
            failures++;
            $display("FAIL backpressure_recover got tready=%b level=%0d required 1 0", s_tready, level);
        end
        @(posedge clk); #1;
        drain(20);
        check_counters("backpressure");
    endtask

    task automatic test_stream();
        m_tready = 1'b0;
        for (int i = 0; i < 14; i++)
            send({8'h01, 8'($urandom_range(0, 31)), 8'($urandom_range(0, 13)), 8'($urandom_range(0, 13))}, 1'b0);
        rand_rdy = 1;
        for (int i = 0; i < 100; i++)
            send({8'h01, 8'($urandom_range(0, 31)), 8'($urandom_range(0, 13)), 8'($urandom_range(0, 13))},
                 1'(i % 25 == 24));
        rand_rdy = 0;
        @(posedge clk); #2 m_tready = 1'b1;
        drain(400);
        check_counters("stream");
    endtask

    task automatic test_clear();
        clear = 1'b1;
        s_tdata = 32'h0100_0001; s_tlast = 1'b0; s_tvalid = 1'b1;
        @(negedge clk);
        if (s_tready) model_push(s_tdata, 1'b0);
        @(posedge clk); #1;
        clear = 1'b0; s_tvalid = 1'b0;
        exp_in = 0; exp_out = 0; exp_drop = 0;
        checks++;
        if (in_cnt !== 32'd0 || drop_cnt !== 32'd0) begin
            failures++;
            $display("FAIL clear_coincident got in=%0d drop=%0d required 0 0", in_cnt, drop_cnt);
        end
        drain(50);
        check_counters("after_clear");
    endtask

    task automatic test_reset_midburst();
        m_tready = 1'b0;
        for (int i = 0; i < 5; i++) send({8'h01, 8'(i), 8'h01, 8'h01}, 1'b0);
        idle(3);
        send(32'h0102_0202, 1'b0);
        checks++;
        if (level !== 5'd5) begin
            failures++;
            $display("FAIL reset_setup_level got=%0d required=5", level);
        end
        #2 rst_n = 1'b0;
        #1;
        exp_q.delete();
        exp_in = 0; exp_out = 0; exp_drop = 0;
        checks++;
        if (m_tvalid !== 1'b0 || level !== 5'd0 || s_tready !== 1'b0) begin
            failures++;
            $display("FAIL reset_midburst got tvalid=%b level=%0d tready=%b required 0 0 0",
                     m_tvalid, level, s_tready);
        end
        enable = 1'b0;
        idle(2);
        rst_n = 1'b1;
        m_tready = 1'b1;
        idle(2);
        @(negedge clk);
        checks++;
        if (s_tready !== 1'b0 || m_tvalid !== 1'b0) begin
            failures++;
            $display("FAIL reset_enable_low got tready=%b tvalid=%b required 0 0", s_tready, m_tvalid);
        end
        @(posedge clk); #1 enable = 1'b1;
        @(negedge clk);
        checks++;
        if (s_tready !== 1'b1) begin
            failures++;
            $display("FAIL reset_enable_high got tready=%b required=1", s_tready);
        end
        @(posedge clk); #1;
        check_counters("reset_midburst");
        send(32'h0103_0405, 1'b1);
        drain(50);
        check_counters("post_reset");
    endtask

    initial begin
        test_reset();
        test_single();
        test_max_and_drop();
        test_null_beat();
        test_backpressure();
        test_stream();
        test_clear();
        test_reset_midburst();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
